bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (CPU = master 0, DMA = master 1) round-robin arbiter in front of one
// shared slave bus, with a per-transaction response timeout.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wrmask,
    input  logic [31:0] m0_wdata,
    output logic        m0_rd_valid,
    output logic        m0_wr_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wrmask,
    input  logic [31:0] m1_wdata,
    output logic        m1_rd_valid,
    output logic        m1_wr_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wrmask,
    output logic [31:0] s_wdata,
    input  logic        s_rd_valid,
    input  logic        s_wr_valid,
    input  logic [31:0] s_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);
    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        m0_req_s, m1_req_s;
    logic        busy_s;
    logic        g_rd_s, g_wr_s, g_req_s;
    logic [31:0] g_addr_s, g_wdata_s;
    logic [3:0]  g_wrmask_s;
    logic        rsp_s, abandon_s, done_s, timeout_s;
    logic        rd_valid_s, wr_valid_s, err_s;
    logic [31:0] rdata_s;

    assign m0_req_s = m0_rd | m0_wr;
    assign m1_req_s = m1_rd | m1_wr;
    assign busy_s   = (state_q == ST_BUSY);

    // Select the request payload of whichever master currently holds the grant.
    always_comb begin
        if (grant_q) begin
            g_rd_s     = m1_rd;
            g_wr_s     = m1_wr;
            g_addr_s   = m1_addr;
            g_wrmask_s = m1_wrmask;
            g_wdata_s  = m1_wdata;
        end else begin
            g_rd_s     = m0_rd;
            g_wr_s     = m0_wr;
            g_addr_s   = m0_addr;
            g_wrmask_s = m0_wrmask;
            g_wdata_s  = m0_wdata;
        end
    end

    // Abandon outranks a response, and a response outranks a timeout in the same cycle.
    assign g_req_s   = g_rd_s | g_wr_s;
    assign rsp_s     = s_rd_valid | s_wr_valid;
    assign abandon_s = busy_s & ~g_req_s;
    assign done_s    = busy_s & g_req_s & rsp_s;
    assign timeout_s = busy_s & g_req_s & ~rsp_s & (cnt_q == CNT_LAST);

    // Shared slave bus: quiet in IDLE, a read wins over a simultaneous write.
    always_comb begin
        s_rd     = 1'b0;
        s_wr     = 1'b0;
        s_addr   = 32'h0000_0000;
        s_wrmask = 4'h0;
        s_wdata  = 32'h0000_0000;
        if (busy_s) begin
            s_rd     = g_rd_s;
            s_wr     = g_wr_s & ~g_rd_s;
            s_addr   = g_addr_s;
            s_wrmask = g_wrmask_s;
            s_wdata  = g_wdata_s;
        end else begin
            s_rd     = 1'b0;
            s_wr     = 1'b0;
        end
    end

    // Completion seen by the granted master: forwarded slave response or timeout error.
    always_comb begin
        rd_valid_s = 1'b0;
        wr_valid_s = 1'b0;
        err_s      = 1'b0;
        rdata_s    = 32'h0000_0000;
        if (done_s) begin
            rd_valid_s = s_rd_valid;
            wr_valid_s = s_wr_valid;
            rdata_s    = s_rdata;
        end else if (timeout_s) begin
            err_s      = 1'b1;
            rd_valid_s = g_rd_s;
            wr_valid_s = ~g_rd_s;
        end else begin
            err_s      = 1'b0;
        end
    end

    // Route the completion to the granted master only; the other one sees zeros.
    always_comb begin
        m0_rd_valid = 1'b0;
        m0_wr_valid = 1'b0;
        m0_rdata    = 32'h0000_0000;
        m0_err      = 1'b0;
        m1_rd_valid = 1'b0;
        m1_wr_valid = 1'b0;
        m1_rdata    = 32'h0000_0000;
        m1_err      = 1'b0;
        if (grant_q) begin
            m1_rd_valid = rd_valid_s;
            m1_wr_valid = wr_valid_s;
            m1_rdata    = rdata_s;
            m1_err      = err_s;
        end else begin
            m0_rd_valid = rd_valid_s;
            m0_wr_valid = wr_valid_s;
            m0_rdata    = rdata_s;
            m0_err      = err_s;
        end
    end

    // Arbitration and transaction-lifetime next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (m0_req_s && m1_req_s) begin
                    grant_d = ~last_grant_q;
                    state_d = ST_BUSY;
                end else if (m0_req_s) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (m1_req_s) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (abandon_s || done_s || timeout_s) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    cnt_d        = 8'd0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers; last_grant resets to 1 so the first contention goes to master 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT=4): a cycle table for contention and
// plain transfers, then hand-written timeout, race, abandon and reset sequences.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wrmask, m1_wrmask;
    logic        m0_rd_valid, m0_wr_valid, m0_err, m1_rd_valid, m1_wr_valid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_rd, s_wr, s_rd_valid, s_wr_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wrmask;

    int n_total = 0;
    int n_pass  = 0;

    // req = {m0_rd,m0_wr,m1_rd,m1_wr}, rsp = {s_rd_valid,s_wr_valid},
    // ctl = {s_rd,s_wr,m0_rd_valid,m0_wr_valid,m0_err,m1_rd_valid,m1_wr_valid,m1_err}
    typedef struct {
        logic [3:0]  req;
        logic [1:0]  rsp;
        logic [31:0] srdata;
        logic [7:0]  e_ctl;
        logic [31:0] e_saddr;
        logic [31:0] e_r0;
        logic [31:0] e_r1;
    } vec_t;

    vec_t vecs[19];

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wrmask(m0_wrmask),
        .m0_wdata(m0_wdata), .m0_rd_valid(m0_rd_valid), .m0_wr_valid(m0_wr_valid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wrmask(m1_wrmask),
        .m1_wdata(m1_wdata), .m1_rd_valid(m1_rd_valid), .m1_wr_valid(m1_wr_valid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wrmask(s_wrmask), .s_wdata(s_wdata),
        .s_rd_valid(s_rd_valid), .s_wr_valid(s_wr_valid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [3:0] req, input logic [1:0] rsp,
                               input logic [31:0] d, input logic [7:0] c,
                               input logic [31:0] a, input logic [31:0] r0,
                               input logic [31:0] r1);
        vec_t t;
        t.req = req; t.rsp = rsp; t.srdata = d;
        t.e_ctl = c; t.e_saddr = a; t.e_r0 = r0; t.e_r1 = r1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t t);
        {m0_rd, m0_wr, m1_rd, m1_wr} = t.req;
        {s_rd_valid, s_wr_valid}     = t.rsp;
        s_rdata                      = t.srdata;
    endtask

    task automatic check_outputs(input vec_t t, input string tag);
        logic [7:0] ctl;
        ctl = {s_rd, s_wr, m0_rd_valid, m0_wr_valid, m0_err, m1_rd_valid, m1_wr_valid, m1_err};
        chk({tag, " ctl"}, {24'h0, ctl}, {24'h0, t.e_ctl});
        chk({tag, " s_addr"}, s_addr, t.e_saddr);
        chk({tag, " m0_rdata"}, m0_rdata, t.e_r0);
        chk({tag, " m1_rdata"}, m1_rdata, t.e_r1);
    endtask

    // One clock cycle: drive just after the rising edge, check on the falling edge.
    task automatic step(input vec_t t, input string tag);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        check_outputs(t, tag);
    endtask

    initial begin
        m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_0000; m0_wrmask = 4'h3;
        m1_addr = 32'hF000_0000; m1_wdata = 32'h2222_0000; m1_wrmask = 4'hC;

        // Contention from reset: grants alternate m0,m1,m0,m1, one wr_valid each.
        vecs[0]  = v(4'b0101, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[1]  = v(4'b0101, 2'b00, 32'h0, 8'h40, 32'h0000_0100, 32'h0, 32'h0);
        vecs[2]  = v(4'b0101, 2'b01, 32'h0, 8'h50, 32'h0000_0100, 32'h0, 32'h0);
        vecs[3]  = v(4'b0101, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[4]  = v(4'b0101, 2'b00, 32'h0, 8'h40, 32'hF000_0000, 32'h0, 32'h0);
        vecs[5]  = v(4'b0101, 2'b01, 32'h0, 8'h42, 32'hF000_0000, 32'h0, 32'h0);
        vecs[6]  = v(4'b0101, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[7]  = v(4'b0101, 2'b00, 32'h0, 8'h40, 32'h0000_0100, 32'h0, 32'h0);
        vecs[8]  = v(4'b0101, 2'b01, 32'h0, 8'h50, 32'h0000_0100, 32'h0, 32'h0);
        vecs[9]  = v(4'b0101, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[10] = v(4'b0101, 2'b00, 32'h0, 8'h40, 32'hF000_0000, 32'h0, 32'h0);
        vecs[11] = v(4'b0101, 2'b01, 32'h0, 8'h42, 32'hF000_0000, 32'h0, 32'h0);
        // Single read by m0, response on the second BUSY cycle.
        vecs[12] = v(4'b1000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[13] = v(4'b1000, 2'b00, 32'h0, 8'h80, 32'h0000_0100, 32'h0, 32'h0);
        vecs[14] = v(4'b1000, 2'b10, 32'hDEAD_BEEF, 8'hA0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
        // Stray response while IDLE must not reach any master.
        vecs[15] = v(4'b0000, 2'b10, 32'h1234_5678, 8'h00, 32'h0, 32'h0, 32'h0);
        // Read and write together: slave sees a read, completion is a read.
        vecs[16] = v(4'b1100, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);
        vecs[17] = v(4'b1100, 2'b10, 32'hA5A5_A5A5, 8'hA0, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0);
        vecs[18] = v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0);

        // Reset held with requests and a response active: everything quiet.
        rst = 1'b0;
        drive(v(4'b1001, 2'b10, 32'hFFFF_FFFF, 8'h00, 32'h0, 32'h0, 32'h0));
        repeat (3) @(negedge clk);
        check_outputs(v(4'b0, 2'b0, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "reset");
        drive(v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0));
        #1 rst = 1'b1;

        for (int i = 0; i < 19; i++) step(vecs[i], $sformatf("vec%0d", i));

        // Timeout: m1 read to an unmapped address, slave silent, error on 4th BUSY cycle.
        step(v(4'b0010, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "to idle");
        for (int i = 0; i < 3; i++)
            step(v(4'b0010, 2'b00, 32'h0, 8'h80, 32'hF000_0000, 32'h0, 32'h0), $sformatf("to wait%0d", i));
        step(v(4'b0010, 2'b00, 32'h0, 8'h85, 32'hF000_0000, 32'h0, 32'h0), "to err");
        step(v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "to after");

        // Race: response on the same cycle the timeout would fire; response wins.
        step(v(4'b1000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "race idle");
        for (int i = 0; i < 3; i++)
            step(v(4'b1000, 2'b00, 32'h0, 8'h80, 32'h0000_0100, 32'h0, 32'h0), $sformatf("race wait%0d", i));
        step(v(4'b1000, 2'b10, 32'hCAFE_F00D, 8'hA0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0), "race rsp");
        step(v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "race after");

        // Abandon: m1 granted (last was m0), drops its read; m0 served after one IDLE.
        step(v(4'b1010, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "ab idle");
        step(v(4'b1010, 2'b00, 32'h0, 8'h80, 32'hF000_0000, 32'h0, 32'h0), "ab busy");
        step(v(4'b1000, 2'b10, 32'hBAD0_BAD0, 8'h00, 32'hF000_0000, 32'h0, 32'h0), "ab drop");
        step(v(4'b1000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "ab gap");
        step(v(4'b1000, 2'b00, 32'h0, 8'h80, 32'h0000_0100, 32'h0, 32'h0), "ab m0");
        step(v(4'b1000, 2'b10, 32'h600D_F00D, 8'hA0, 32'h0000_0100, 32'h600D_F00D, 32'h0), "ab m0 rsp");
        step(v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "ab after");

        // Reset two cycles into an m0 write; then contention after release goes to m0.
        step(v(4'b0100, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "rst idle");
        step(v(4'b0100, 2'b00, 32'h0, 8'h40, 32'h0000_0100, 32'h0, 32'h0), "rst busy0");
        step(v(4'b0100, 2'b00, 32'h0, 8'h40, 32'h0000_0100, 32'h0, 32'h0), "rst busy1");
        #1 rst = 1'b0;
        #1 check_outputs(v(4'b0, 2'b0, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "rst async");
        drive(v(4'b0101, 2'b01, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0));
        repeat (2) @(negedge clk);
        check_outputs(v(4'b0, 2'b0, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "rst held");
        drive(v(4'b0101, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0));
        #1 rst = 1'b1;
        step(v(4'b0101, 2'b00, 32'h0, 8'h40, 32'h0000_0100, 32'h0, 32'h0), "rst regrant");
        chk("rst s_wdata", s_wdata, 32'h1111_0000);
        chk("rst s_wrmask", {28'h0, s_wrmask}, 32'h0000_0003);
        step(v(4'b0101, 2'b01, 32'h0, 8'h50, 32'h0000_0100, 32'h0, 32'h0), "rst done");
        step(v(4'b0000, 2'b00, 32'h0, 8'h00, 32'h0, 32'h0, 32'h0), "rst after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
